// File: rtl/tile_fb.sv
// Tile framebuffer: COLS x ROWS tiles of 9-bit colour, each covering an 8x8 pixel block, scanned out
// with a fixed 2-cycle latency. Optional fill-all clear FSM is built only when TILE_FB_CLEAR_EN is defined.
module tile_fb #(
   parameter int COLS = 80,
   parameter int ROWS = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] h_idx,
   input  logic [9:0] v_idx,
   input  logic       in_valid,
   input  logic       in_hsync,
   input  logic       in_vsync,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic [6:0] wr_x,
   input  logic [5:0] wr_y,
   input  logic [8:0] wr_color,
   input  logic       clear_req,
   input  logic [8:0] clear_color,
   output logic       clear_busy,
   output logic [2:0] red,
   output logic [2:0] green,
   output logic [2:0] blue,
   output logic       out_hsync,
   output logic       out_vsync,
   output logic       out_valid
);

   localparam int NT = COLS * ROWS;
   localparam int AW = $clog2(NT);

   logic [8:0]    mem [NT];
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic [1:0]    vld_q, vld_d, hs_q, hs_d, vs_q, vs_d;
   logic [8:0]    color_q, color_d;
   logic          we_q, we_d;
   logic [AW-1:0] waddr_q, waddr_d;
   logic [8:0]    wdata_q, wdata_d;
   logic          wr_in_range;
   logic          clr_we;
   logic [AW-1:0] clr_addr;
   logic [8:0]    clr_color;
   logic          unused_bits;

`ifdef TILE_FB_CLEAR_EN
   // state   | meaning
   // S_IDLE  | no fill in progress, tile writes allowed
   // S_CLEAR | writing latched colour to tile cnt_q on each blanking cycle
   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t        state_q;
   logic [AW-1:0] cnt_q;
   logic [8:0]    clr_color_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         clr_color_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (clear_req) begin
                  state_q     <= S_CLEAR;
                  clr_color_q <= clear_color;
                  cnt_q       <= '0;
               end
            end
            S_CLEAR: begin
               if (!in_valid) begin
                  if (cnt_q == AW'(NT - 1)) begin
                     state_q <= S_IDLE;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + AW'(1);
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign clear_busy  = (state_q == S_CLEAR);
   assign clr_we      = clear_busy && !in_valid;
   assign clr_addr    = cnt_q;
   assign clr_color   = clr_color_q;
   assign unused_bits = ^{h_idx[2:0], v_idx[2:0]};
`else
   assign clear_busy  = 1'b0;
   assign clr_we      = 1'b0;
   assign clr_addr    = '0;
   assign clr_color   = '0;
   assign unused_bits = ^{h_idx[2:0], v_idx[2:0], clear_req, clear_color};
`endif

   assign wr_in_range = (int'(wr_x) < COLS) && (int'(wr_y) < ROWS);

   // Accepted writes land in RAM one cycle later, when the previous cycle was blanking, so the
   // single RAM port never sees a read and a write together.
   always_comb begin
      wr_ready  = !in_valid && !clear_busy && !rst;
      rd_addr_d = AW'(int'(v_idx[9:3]) * COLS + int'(h_idx[9:3]));
      vld_d     = {vld_q[0], in_valid};
      hs_d      = {hs_q[0], in_hsync};
      vs_d      = {vs_q[0], in_vsync};
      color_d   = vld_q[0] ? mem[rd_addr_q] : '0;
      we_d      = clr_we || (wr_valid && wr_ready && wr_in_range);
      waddr_d   = clr_we ? clr_addr : AW'(int'(wr_y) * COLS + int'(wr_x));
      wdata_d   = clr_we ? clr_color : wr_color;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_addr_q <= '0;
         vld_q     <= '0;
         hs_q      <= 2'b11;
         vs_q      <= 2'b11;
         color_q   <= '0;
         we_q      <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
      end else begin
         rd_addr_q <= rd_addr_d;
         vld_q     <= vld_d;
         hs_q      <= hs_d;
         vs_q      <= vs_d;
         color_q   <= color_d;
         we_q      <= we_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (we_q) mem[waddr_q] <= wdata_q;
   end

   assign out_valid = vld_q[1];
   assign out_hsync = hs_q[1];
   assign out_vsync = vs_q[1];
   assign red       = out_valid ? color_q[8:6] : 3'd0;
   assign green     = out_valid ? color_q[5:3] : 3'd0;
   assign blue      = out_valid ? color_q[2:0] : 3'd0;

endmodule

// File: tb/tb_tile_fb.sv
// Bench for tile_fb: directed and random scan/write traffic checked against a tile-array model.
// Clear-FSM scenarios are included when TILE_FB_CLEAR_EN is defined.
module tb_tile_fb;
   localparam int COLS = 80;
   localparam int ROWS = 60;
   localparam int NT   = COLS * ROWS;
   localparam logic [11:0] RST_OUT = {1'b0, 1'b1, 1'b1, 9'h000};

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] h_idx, v_idx;
   logic       in_valid, in_hsync, in_vsync;
   logic       wr_valid, wr_ready;
   logic [6:0] wr_x;
   logic [5:0] wr_y;
   logic [8:0] wr_color;
   logic       clear_req;
   logic [8:0] clear_color;
   logic       clear_busy;
   logic [2:0] red, green, blue;
   logic       out_hsync, out_vsync, out_valid;

   tile_fb #(.COLS(COLS), .ROWS(ROWS)) dut (
      .clk(clk), .rst(rst), .h_idx(h_idx), .v_idx(v_idx),
      .in_valid(in_valid), .in_hsync(in_hsync), .in_vsync(in_vsync),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
      .clear_req(clear_req), .clear_color(clear_color), .clear_busy(clear_busy),
      .red(red), .green(green), .blue(blue),
      .out_hsync(out_hsync), .out_vsync(out_vsync), .out_valid(out_valid)
   );

   always #20 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int dut_acc = 0;
   int dut_clr_w = 0;
   logic [8:0]  model_mem [NT];
   logic [11:0] exp_q [$];
   bit          m_busy = 1'b0;
`ifdef TILE_FB_CLEAR_EN
   int          clr_k = 0;
   logic [8:0]  clr_c = '0;
`endif

   // Model: a pixel shows its tile's colour two cycles after it is presented; an accepted write is
   // visible to any pixel presented on a later cycle.
   task automatic tick();
      logic        exp_ready;
      logic [11:0] e, got;
      #1;
      exp_ready = !in_valid && !m_busy && !rst;
      checks++;
      assert (wr_ready === exp_ready) else begin
         errors++;
         $error("FAIL wr_ready h=%0d v=%0d got=%b exp=%b", h_idx, v_idx, wr_ready, exp_ready);
      end
      checks++;
      assert (clear_busy === m_busy) else begin
         errors++;
         $error("FAIL clear_busy got=%b exp=%b", clear_busy, m_busy);
      end
      if (wr_valid && wr_ready) dut_acc++;
      if (clear_busy && !in_valid && !rst) dut_clr_w++;
      if (rst) begin
         exp_q.delete();
         exp_q.push_back(RST_OUT);
         exp_q.push_back(RST_OUT);
      end else if (in_valid) begin
         exp_q.push_back({1'b1, in_hsync, in_vsync,
                          model_mem[(int'(v_idx) / 8) * COLS + int'(h_idx) / 8]});
      end else begin
         exp_q.push_back({1'b0, in_hsync, in_vsync, 9'h000});
      end
      if (wr_valid && exp_ready && int'(wr_x) < COLS && int'(wr_y) < ROWS)
         model_mem[int'(wr_y) * COLS + int'(wr_x)] = wr_color;
`ifdef TILE_FB_CLEAR_EN
      if (rst) begin
         m_busy = 1'b0;
      end else if (m_busy) begin
         if (!in_valid) begin
            model_mem[clr_k] = clr_c;
            clr_k++;
            if (clr_k == NT) m_busy = 1'b0;
         end
      end else if (clear_req) begin
         m_busy = 1'b1;
         clr_k  = 0;
         clr_c  = clear_color;
      end
`endif
      @(posedge clk);
      #1;
      e   = exp_q.pop_front();
      got = {out_valid, out_hsync, out_vsync, red, green, blue};
      checks++;
      assert (got === e) else begin
         errors++;
         $error("FAIL pixel_out {valid,hs,vs,rgb} got=%h exp=%h", got, e);
      end
   endtask

   task automatic pix_in_tile(input int t);
      in_valid = 1'b1;
      h_idx    = 10'((t % COLS) * 8 + int'($urandom_range(7)));
      v_idx    = 10'((t / COLS) * 8 + int'($urandom_range(7)));
   endtask

   task automatic flush();
      in_valid = 1'b0;
      wr_valid = 1'b0;
      h_idx    = 10'd700;
      v_idx    = 10'd490;
      tick();
      tick();
   endtask

   initial begin
      int k, n, acc0;
      rst = 1'b1; h_idx = '0; v_idx = '0; in_valid = 1'b0; in_hsync = 1'b1; in_vsync = 1'b1;
      wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_color = '0; clear_req = 1'b0; clear_color = '0;
      repeat (3) tick();
      checks++;
      assert ({out_valid, out_hsync, out_vsync, red, green, blue} === RST_OUT) else begin
         errors++;
         $error("FAIL reset_out got=%h exp=%h", {out_valid, out_hsync, out_vsync, red, green, blue}, RST_OUT);
      end
      rst = 1'b0;

`ifdef TILE_FB_CLEAR_EN
      clear_color = 9'h007; clear_req = 1'b1;
      tick();
      clear_req = 1'b0; clear_color = 9'h1FF;
      dut_clr_w = 0;
      n = 0;
      while (m_busy && n < 20000) begin
         if (clr_k > 0 && $urandom_range(3) == 0) begin
            k = int'($urandom_range(clr_k - 1));
            pix_in_tile(k);
         end else begin
            in_valid = 1'b0; h_idx = 10'd700; v_idx = 10'd490;
         end
         wr_valid  = 1'($urandom_range(1));
         wr_x      = 7'($urandom_range(COLS - 1));
         wr_y      = 6'($urandom_range(ROWS - 1));
         wr_color  = 9'($urandom);
         clear_req = 1'($urandom_range(1));
         tick();
         n++;
      end
      clear_req = 1'b0;
      flush();
      checks++;
      assert (dut_clr_w === NT) else begin
         errors++;
         $error("FAIL clear_write_cycles got=%0d exp=%0d", dut_clr_w, NT);
      end
      for (int i = 0; i < 300; i++) begin
         pix_in_tile(int'($urandom_range(NT - 1)));
         tick();
      end
      flush();
`else
      clear_req = 1'b1; clear_color = 9'h0AA;
`endif

      // fill every tile with a random colour, with scanout cycles interleaved
      k = 0; n = 0;
      while (k < NT && n < 20000) begin
         if (k > 0 && $urandom_range(4) == 0) pix_in_tile(int'($urandom_range(k - 1)));
         else begin in_valid = 1'b0; h_idx = 10'd650; v_idx = 10'd10; end
         wr_valid = 1'b1;
         wr_x     = 7'(k % COLS);
         wr_y     = 6'(k / COLS);
         wr_color = 9'($urandom);
         n++;
         if (!in_valid) begin
            tick();
            k++;
         end else begin
            tick();
         end
      end
      clear_req = 1'b0;
      flush();

      in_valid = 1'b0; wr_valid = 1'b1; wr_x = 7'd5; wr_y = 6'd2; wr_color = 9'h1C0;
      tick();
      wr_valid = 1'b0;
      for (int h = 40; h < 48; h++) begin
         in_valid = 1'b1; h_idx = 10'(h); v_idx = 10'd16;
         tick();
         if (h == 41) begin
            checks++;
            assert ({red, green, blue} === 9'h1C0) else begin
               errors++;
               $error("FAIL tile_5_2_rgb got=%h exp=%h", {red, green, blue}, 9'h1C0);
            end
         end
      end
      flush();

      acc0 = dut_acc;
      wr_valid = 1'b1; wr_x = 7'd10; wr_y = 6'd12; wr_color = 9'($urandom);
      for (int h = 100; h < 640; h++) begin
         in_valid = 1'b1; h_idx = 10'(h); v_idx = 10'd100;
         tick();
      end
      in_valid = 1'b0; h_idx = 10'd640;
      tick();
      wr_valid = 1'b0;
      checks++;
      assert (dut_acc - acc0 === 1) else begin
         errors++;
         $error("FAIL held_write_handshakes got=%0d exp=1", dut_acc - acc0);
      end
      for (int h = 80; h < 88; h++) begin
         in_valid = 1'b1; h_idx = 10'(h); v_idx = 10'd96;
         tick();
      end
      flush();

      acc0 = dut_acc;
      wr_valid = 1'b1; wr_color = 9'h1FF;
      wr_x = 7'd80;  wr_y = 6'd0;  tick();
      wr_x = 7'd0;   wr_y = 6'd60; tick();
      wr_x = 7'd127; wr_y = 6'd63; tick();
      wr_valid = 1'b0;
      checks++;
      assert (dut_acc - acc0 === 3) else begin
         errors++;
         $error("FAIL out_of_range_handshakes got=%0d exp=3", dut_acc - acc0);
      end
      in_valid = 1'b1; h_idx = 10'd0;   v_idx = 10'd0; tick();
      in_valid = 1'b1; h_idx = 10'd3;   v_idx = 10'd8; tick();
      in_valid = 1'b1; h_idx = 10'd639; v_idx = 10'd0; tick();
      in_valid = 1'b1; h_idx = 10'd0;   v_idx = 10'd479; tick();
      flush();

      for (int h = 630; h < 800; h++) begin
         in_valid = (h < 640); h_idx = 10'(h); v_idx = 10'd200;
         in_hsync = !(h >= 656 && h < 752);
         tick();
      end
      in_hsync = 1'b1;
      in_vsync = 1'b0; repeat (4) tick();
      in_vsync = 1'b1; flush();

      for (int i = 0; i < 3000; i++) begin
         in_valid = ($urandom_range(2) != 0);
         if (in_valid) begin
            h_idx = 10'($urandom_range(639)); v_idx = 10'($urandom_range(479));
         end else begin
            h_idx = 10'($urandom_range(799, 640)); v_idx = 10'($urandom_range(524));
         end
         in_hsync = 1'($urandom_range(1));
         in_vsync = 1'($urandom_range(1));
         wr_valid = 1'($urandom_range(1));
         wr_x     = 7'($urandom_range(127));
         wr_y     = 6'($urandom_range(63));
         wr_color = 9'($urandom);
         tick();
      end
      in_hsync = 1'b1; in_vsync = 1'b1;
      flush();

`ifdef TILE_FB_CLEAR_EN
      clear_color = 9'h038; clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      repeat (100) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      assert (clear_busy === 1'b0) else begin
         errors++;
         $error("FAIL clear_busy_after_rst got=%b exp=0", clear_busy);
      end
      tick();
      tick();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tile_fb.md
TILE_FB -- requirements
Module: tile_fb

Interface
REQ-001 SHALL declare parameter COLS, default 80, tile columns (640/8).
REQ-002 SHALL declare parameter ROWS, default 60, tile rows (480/8).
REQ-003 SHALL have port clk  input  1  pixel clock, 25 MHz.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports h_idx, v_idx  input  10 each  column/row from the timing generator.
REQ-006 SHALL have ports in_valid, in_hsync, in_vsync  input  1 each  active-area flag and syncs from the timing generator.
REQ-007 SHALL have ports wr_valid  input  1, wr_ready  output  1  tile-write handshake.
REQ-008 SHALL have ports wr_x  input  7, wr_y  input  6, wr_color  input  9  tile coordinate and {r[2:0],g[2:0],b[2:0]}.
REQ-009 SHALL have ports clear_req  input  1, clear_color  input  9, clear_busy  output  1  fill-all control.
REQ-010 SHALL have ports red, green, blue  output  3 each, out_hsync, out_vsync, out_valid  output  1 each  aligned pixel stream to the VGA pins.

Function
REQ-011 SHALL store COLS*ROWS 9-bit tile colours in a single-port RAM; each tile covers an 8x8 pixel block.
REQ-012 SHALL, on cycle N, compute addr = (v_idx>>3)*COLS + (h_idx>>3) and register it; the RAM is read on N+1; colour is registered on N+2.
REQ-013 SHALL delay in_valid, in_hsync and in_vsync by exactly 2 cycles to produce out_valid, out_hsync and out_vsync.
REQ-014 SHALL drive red/green/blue to 0 whenever out_valid is 0.
REQ-015 SHALL perform a RAM read only when in_valid=1; all RAM writes occur only when in_valid=0.
REQ-016 SHALL assert wr_ready = !in_valid && !clear_busy && !rst, combinationally.
REQ-017 SHALL write wr_color to tile (wr_x,wr_y) on the cycle wr_valid && wr_ready is high; the write is visible to any scanout read starting on the next cycle.
REQ-018 SHALL accept but discard writes with wr_x >= COLS or wr_y >= ROWS (handshake completes, RAM unchanged).
REQ-019 SHALL hold wr_ready low for the entire active region; a held wr_valid completes on the first blanking cycle.
REQ-020 SHALL implement a clear FSM with states IDLE and CLEAR; IDLE->CLEAR when clear_req=1 in IDLE, latching clear_color.
REQ-021 SHALL, in CLEAR, write the latched colour to address cnt and increment cnt on each cycle in_valid=0; cnt stalls while in_valid=1.
REQ-022 SHALL go CLEAR->IDLE on the cycle address COLS*ROWS-1 is written, resetting cnt to 0.
REQ-023 SHALL assert clear_busy exactly while in CLEAR; clear_req in CLEAR is ignored.
REQ-024 SHALL give the clear FSM priority over wr_* (enforced via wr_ready).

Reset
REQ-025 SHALL, on rst, set FSM to IDLE, cnt to 0, clear_busy to 0, all pipeline registers to 0, so red/green/blue = 0 and out_valid = 0 on the next cycle; out_hsync and out_vsync SHALL reset to 1 (inactive).
REQ-026 SHALL NOT initialise RAM contents on rst; a reset mid-clear leaves partially filled RAM and returns to IDLE.

Configuration
REQ-027 SHALL compile the clear FSM only when TILE_FB_CLEAR_EN is defined; with it defined, REQ-020..REQ-024 apply.
REQ-028 SHALL, without TILE_FB_CLEAR_EN, keep clear_req/clear_color ports, ignore them, and tie clear_busy to 0.

Verification
REQ-029 SHALL cover: write (5,2)=9'h1C0 in blanking; scan h_idx=40..47, v_idx=16 -> red=7, green=0, blue=0 two cycles later.
REQ-030 SHALL cover: wr_valid held from h_idx=100, in_valid=1 -> wr_ready=0 until h_idx=640 (in_valid=0), handshake completes that cycle.
REQ-031 SHALL cover: write (80,0)=9'h1FF -> accepted, no tile changes; pixel (0,0) unchanged.
REQ-032 SHALL cover: in_hsync falling at h_idx=656 -> out_hsync falls 2 cycles later; pixels with in_valid=0 -> RGB=0.
REQ-033 SHALL cover (TILE_FB_CLEAR_EN): clear_req with clear_color=9'h007 -> clear_busy high for 4800 blanking-write cycles, all pixels then blue=7; rst mid-clear -> clear_busy=0 next cycle.
REQ-034 SHALL cover (no macro): clear_req pulse -> clear_busy stays 0, RAM unchanged, wr_ready follows REQ-016.
